// File: rtl/ro_puf_ctrl.sv
// Ring-oscillator PUF controller: settles, counts edges of two challenge-selected oscillators, compares.
// Define RO_PUF_CTRL_MARGIN_EN to report |cntA-cntB| on margin; otherwise margin is tied to zero.
module ro_puf_ctrl #(
  parameter int SETTLE_CYCLES = 16,
  parameter int WINDOW_CYCLES = 4096,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       challenge,
  input  logic [15:0]      ro_outputs,
  output logic             ro_enable,
  output logic             busy,
  output logic             resp_valid,
  output logic             response,
  output logic             resp_err,
  output logic [CNT_W-1:0] margin
);

  localparam int MAX_CYC = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    MEASURE = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [7:0]         chal_q, chal_d;
  logic [CNT_W-1:0]   cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]   cnt_b_q, cnt_b_d;
  logic [15:0]        sync1_q, sync1_d;
  logic [15:0]        sync2_q, sync2_d;
  logic [15:0]        sync3_q, sync3_d;
  logic               ro_enable_q, ro_enable_d;
  logic               busy_q, busy_d;
  logic               resp_valid_q, resp_valid_d;
  logic               response_q, response_d;
  logic               resp_err_q, resp_err_d;
`ifdef RO_PUF_CTRL_MARGIN_EN
  logic [CNT_W-1:0]   margin_q, margin_d;
`endif

  logic rise_a, rise_b;

  // Edge detect sits on the already-synchronized 2nd/3rd stages, so counting never sees metastable data.
  assign rise_a = sync2_q[chal_q[7:4]] & ~sync3_q[chal_q[7:4]];
  assign rise_b = sync2_q[chal_q[3:0]] & ~sync3_q[chal_q[3:0]];

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    chal_d       = chal_q;
    cnt_a_d      = cnt_a_q;
    cnt_b_d      = cnt_b_q;
    sync1_d      = ro_outputs;
    sync2_d      = sync1_q;
    sync3_d      = sync2_q;
    resp_valid_d = 1'b0;
    response_d   = response_q;
    resp_err_d   = resp_err_q;
`ifdef RO_PUF_CTRL_MARGIN_EN
    margin_d     = margin_q;
`endif

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          chal_d  = challenge;
          cnt_a_d = '0;
          cnt_b_d = '0;
          timer_d = '0;
          if (challenge[7:4] == challenge[3:0]) begin
            state_d    = DONE;
            resp_err_d = 1'b1;
            response_d = 1'b0;
`ifdef RO_PUF_CTRL_MARGIN_EN
            margin_d   = '0;
`endif
          end else begin
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (timer_q == SETTLE_LAST) begin
          state_d = MEASURE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      MEASURE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          // Counters stick at all-ones so a fast oscillator can never wrap below a slow one.
          if (rise_a && (cnt_a_q != '1)) cnt_a_d = cnt_a_q + CNT_W'(1);
          if (rise_b && (cnt_b_q != '1)) cnt_b_d = cnt_b_q + CNT_W'(1);
          if (timer_q == WINDOW_LAST) begin
            state_d = COMPARE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end
      COMPARE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          response_d = (cnt_a_q > cnt_b_q);
          resp_err_d = 1'b0;
`ifdef RO_PUF_CTRL_MARGIN_EN
          margin_d   = (cnt_a_q > cnt_b_q) ? (cnt_a_q - cnt_b_q) : (cnt_b_q - cnt_a_q);
`endif
          state_d    = DONE;
        end
      end
      DONE: begin
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ro_enable_d = (state_d == SETTLE) || (state_d == MEASURE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      chal_q       <= '0;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      sync3_q      <= '0;
      ro_enable_q  <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      response_q   <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      chal_q       <= chal_d;
      cnt_a_q      <= cnt_a_d;
      cnt_b_q      <= cnt_b_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sync3_q      <= sync3_d;
      ro_enable_q  <= ro_enable_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      response_q   <= response_d;
      resp_err_q   <= resp_err_d;
    end
  end

`ifdef RO_PUF_CTRL_MARGIN_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) margin_q <= '0;
    else          margin_q <= margin_d;
  end
  assign margin = margin_q;
`else
  assign margin = '0;
`endif

  assign ro_enable  = ro_enable_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign response   = response_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Self-checking bench for ro_puf_ctrl: a 16-bit and a 4-bit counter instance share all stimulus.
// Expected counts come from the recorded oscillator history; honours RO_PUF_CTRL_MARGIN_EN.
module tb_ro_puf_ctrl;

  localparam int S    = 4;
  localparam int W    = 96;
  localparam int HIST = 16384;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [7:0]  challenge;
  logic [15:0] ro_outputs = '0;

  logic        en16, busy16, rv16, resp16, err16;
  logic [15:0] margin16;
  logic        en4, busy4, rv4, resp4, err4;
  logic [3:0]  margin4;

  int          testCount = 0;
  int          failCount = 0;
  int          cyc = 0;
  int          rvCount = 0;
  int          enCount = 0;
  logic [15:0] hist [HIST];
  int          halfP [16];
  int          phase [16];

  // Result the outputs should currently be holding, used to prove abort/reset leave them alone.
  logic        expResp16 = 1'b0, expErr16 = 1'b0;
  logic [15:0] expMargin16 = '0;

  ro_puf_ctrl #(.SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .CNT_W(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .challenge(challenge),
    .ro_outputs(ro_outputs), .ro_enable(en16), .busy(busy16), .resp_valid(rv16),
    .response(resp16), .resp_err(err16), .margin(margin16));

  ro_puf_ctrl #(.SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .challenge(challenge),
    .ro_outputs(ro_outputs), .ro_enable(en4), .busy(busy4), .resp_valid(rv4),
    .response(resp4), .resp_err(err4), .margin(margin4));

  always #5 clk = ~clk;

  // Record what the first synchronizer stage samples on every rising edge.
  always @(posedge clk) begin
    if (cyc < HIST) hist[cyc] = ro_outputs;
    cyc++;
  end

  // Oscillator model: bit i toggles every halfP[i] cycles (0 = held low), changed away from the sampling edge.
  always @(negedge clk) begin
    logic [15:0] v;
    for (int i = 0; i < 16; i++)
      v[i] = (halfP[i] == 0) ? 1'b0 : ((((cyc + phase[i]) / halfP[i]) % 2) == 1);
    ro_outputs = v;
  end

  always @(negedge clk) begin
    if (rv16) rvCount++;
    if (en16) enCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Rising edges of oscillator idx seen by the counter: window of W edges starting S+1 after accept,
  // each edge looking at the transition two and three samples back (synchronizer latency).
  function automatic int edgesSeen(input int acc, input int idx);
    int n = 0;
    for (int m = acc + S + 1; m <= acc + S + W; m++)
      if (hist[m-2][idx] && !hist[m-3][idx]) n++;
    return n;
  endfunction

  task automatic applyStimulus(input logic [7:0] chal, input bit inject);
    int acc, k, enBase, ca, cb, expLat, expEn;
    bit got;
    logic [3:0] a, b;
    logic [15:0] sa16, sb16;
    logic [3:0]  sa4, sb4;
    logic expR16, expR4, expE;
    logic [15:0] expM16;
    logic [3:0]  expM4;
    @(negedge clk);
    enBase = enCount;
    start = 1'b1;
    challenge = chal;
    @(negedge clk);
    start = 1'b0;
    acc = cyc - 1;
    challenge = 8'($urandom);
    checkOutput("busy_after_accept", {31'd0, busy16}, 32'd1);
    k = 0;
    got = 1'b0;
    while (!got && k < S + W + 20) begin
      if (inject && k == S + 20) begin
        start = 1'b1;
        challenge = 8'h12;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
      if (rv16) got = 1'b1;
    end
    start = 1'b0;
    a = chal[7:4];
    b = chal[3:0];
    if (a == b) begin
      expLat = 1; expEn = 0; expE = 1'b1;
      expR16 = 1'b0; expR4 = 1'b0; expM16 = '0; expM4 = '0;
    end else begin
      expLat = S + W + 2; expEn = S + W; expE = 1'b0;
      ca = edgesSeen(acc, a);
      cb = edgesSeen(acc, b);
      sa16 = (ca > 65535) ? 16'hFFFF : 16'(ca);
      sb16 = (cb > 65535) ? 16'hFFFF : 16'(cb);
      sa4  = (ca > 15) ? 4'hF : 4'(ca);
      sb4  = (cb > 15) ? 4'hF : 4'(cb);
      expR16 = sa16 > sb16;
      expR4  = sa4 > sb4;
`ifdef RO_PUF_CTRL_MARGIN_EN
      expM16 = (sa16 > sb16) ? sa16 - sb16 : sb16 - sa16;
      expM4  = (sa4 > sb4) ? sa4 - sb4 : sb4 - sa4;
`else
      expM16 = '0;
      expM4  = '0;
`endif
    end
    checkOutput("latency", k, expLat);
    checkOutput("valid4_aligned", {31'd0, rv4}, 32'd1);
    checkOutput("response16", {31'd0, resp16}, {31'd0, expR16});
    checkOutput("resp_err16", {31'd0, err16}, {31'd0, expE});
    checkOutput("margin16", {16'd0, margin16}, {16'd0, expM16});
    checkOutput("response4", {31'd0, resp4}, {31'd0, expR4});
    checkOutput("resp_err4", {31'd0, err4}, {31'd0, expE});
    checkOutput("margin4", {28'd0, margin4}, {28'd0, expM4});
    @(negedge clk);
    checkOutput("valid_one_cycle", {31'd0, rv16}, 32'd0);
    checkOutput("response_held", {31'd0, resp16}, {31'd0, expR16});
    checkOutput("enable_cycles", enCount - enBase, expEn);
    expResp16 = expR16;
    expErr16 = expE;
    expMargin16 = expM16;
  endtask

  task automatic setPattern(input int h3, input int h5);
    for (int i = 0; i < 16; i++) begin
      halfP[i] = 0;
      phase[i] = 0;
    end
    halfP[3] = h3;
    halfP[5] = h5;
  endtask

  initial begin
    int rvBase;
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    challenge = 8'h00;
    setPattern(0, 0);
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy16}, 32'd0);
    checkOutput("reset_enable", {31'd0, en16}, 32'd0);
    checkOutput("reset_valid", {31'd0, rv16}, 32'd0);
    checkOutput("reset_outputs", {15'd0, resp16, err16, margin16}, 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] scenario 1/2: ro[3] vs ro[5]");
    setPattern(2, 3);
    repeat (4) @(negedge clk);
    applyStimulus(8'h35, 1'b0);
    checkOutput("s1_response", {31'd0, resp16}, 32'd1);
`ifdef RO_PUF_CTRL_MARGIN_EN
    checkOutput("s1_margin_near_8", {31'd0, (margin16 >= 16'd7 && margin16 <= 16'd9)}, 32'd1);
`endif
    applyStimulus(8'h53, 1'b0);
    checkOutput("s2_response", {31'd0, resp16}, 32'd0);

    $display("[TB] scenario 3: equal indices");
    applyStimulus(8'h77, 1'b0);
    checkOutput("s3_err", {31'd0, err16}, 32'd1);

    $display("[TB] scenario 4: saturation");
    setPattern(0, 0);
    halfP[0] = 1;
    repeat (4) @(negedge clk);
    applyStimulus(8'h01, 1'b0);
    checkOutput("s4_response4", {31'd0, resp4}, 32'd1);
`ifdef RO_PUF_CTRL_MARGIN_EN
    checkOutput("s4_margin4", {28'd0, margin4}, 32'd15);
`endif

    $display("[TB] abort with start in IDLE");
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checkOutput("abort_start_idle", {30'd0, busy16, en16}, 32'd0);
    repeat (2) @(negedge clk);

    $display("[TB] scenario 5: abort in MEASURE");
    setPattern(2, 3);
    repeat (4) @(negedge clk);
    applyStimulus(8'h35, 1'b0);
    @(negedge clk);
    rvBase = rvCount;
    start = 1'b1;
    challenge = 8'h53;
    @(negedge clk);
    start = 1'b0;
    repeat (S + 10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_busy", {31'd0, busy16}, 32'd0);
    checkOutput("abort_enable", {31'd0, en16}, 32'd0);
    checkOutput("abort_response", {31'd0, resp16}, {31'd0, expResp16});
    checkOutput("abort_err", {31'd0, err16}, {31'd0, expErr16});
    checkOutput("abort_margin", {16'd0, margin16}, {16'd0, expMargin16});
    repeat (W + 10) @(negedge clk);
    checkOutput("abort_no_valid", rvCount - rvBase, 32'd0);
    applyStimulus(8'h53, 1'b0);

    $display("[TB] scenario 6: start while busy, reset mid-SETTLE");
    applyStimulus(8'h35, 1'b1);
    @(negedge clk);
    rvBase = rvCount;
    start = 1'b1;
    challenge = 8'h35;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_outputs", {12'd0, en16, busy16, rv16, resp16, err16, margin16}, 32'd0);
    checkOutput("async_reset_outputs4", {24'd0, en4, busy4, rv4, resp4, err4, margin4}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (W + 20) @(negedge clk);
    checkOutput("reset_no_valid", rvCount - rvBase, 32'd0);
    checkOutput("reset_stays_idle", {31'd0, busy16}, 32'd0);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 16; i++) begin
        halfP[i] = $urandom_range(0, 7);
        phase[i] = $urandom_range(0, 15);
      end
      repeat (4) @(negedge clk);
      applyStimulus(8'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
